// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, branch condition codes, PC sequencer states,
// and the PC-relative branch target calculation.
package cpu_pkg;

    localparam int unsigned PC_W = 16;

    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_PCS = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // Flag order on the flags bus is {V, N, Z}.
    typedef enum logic [2:0] {
        CC_NE = 3'b000,
        CC_EQ = 3'b001,
        CC_GT = 3'b010,
        CC_LT = 3'b011,
        CC_GE = 3'b100,
        CC_LE = 3'b101,
        CC_VS = 3'b110,
        CC_AL = 3'b111
    } cond_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    // imm9 is a signed word offset, so it is scaled to bytes before being added.
    function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] pc_plus2,
                                                      input logic [8:0]      imm9);
        logic [PC_W-1:0] offset;
        offset = {{6{imm9[8]}}, imm9, 1'b0};
        return pc_plus2 + offset;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational evaluation of a branch condition code against the registered ALU flags.
module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       cond_true
);

    logic flag_v;
    logic flag_n;
    logic flag_z;

    assign flag_v = flags[2];
    assign flag_n = flags[1];
    assign flag_z = flags[0];

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            CC_NE:   cond_true = !flag_z;
            CC_EQ:   cond_true = flag_z;
            CC_GT:   cond_true = !flag_z && !flag_n;
            CC_LT:   cond_true = flag_n;
            CC_GE:   cond_true = flag_z || (!flag_z && !flag_n);
            CC_LE:   cond_true = flag_n || flag_z;
            CC_VS:   cond_true = flag_v;
            CC_AL:   cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_control.sv
// Program counter sequencer: BOOT/RUN/HALT control, conditional B/BR redirection,
// and sequential pc+2 advance with stall hold.
module pc_control
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned BOOT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    input  logic [2:0]  cond,
    input  logic [8:0]  imm9,
    input  logic [15:0] rs_val,
    input  logic [2:0]  flags,
    input  logic        stall,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2,
    output logic        fetch_en,
    output logic        taken,
    output logic        halted
);

    localparam logic [2:0] BOOT_LAST = 3'(BOOT_CYCLES - 1);

    state_e      state_q;
    state_e      state_d;
    logic [2:0]  boot_cnt_q;
    logic [2:0]  boot_cnt_d;
    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic        cond_true;
    logic        is_branch;

    branch_cond u_branch_cond (
        .cond      (cond),
        .flags     (flags),
        .cond_true (cond_true)
    );

    assign pc        = pc_q;
    assign pc_plus2  = pc_q + 16'd2;
    assign is_branch = (opcode == OP_B) || (opcode == OP_BR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            boot_cnt_q <= 3'd0;
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pc_q       <= pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        boot_cnt_d = boot_cnt_q;
        pc_d       = pc_q;
        fetch_en   = 1'b0;
        taken      = 1'b0;
        halted     = 1'b0;

        case (state_q)
            ST_BOOT: begin
                if (!stall) begin
                    if (boot_cnt_q == BOOT_LAST) begin
                        state_d    = ST_RUN;
                        boot_cnt_d = 3'd0;
                    end else begin
                        boot_cnt_d = boot_cnt_q + 3'd1;
                    end
                end
            end
            ST_RUN: begin
                fetch_en = 1'b1;
                // A stalled cycle neither redirects nor halts; it simply repeats next cycle.
                if (!stall) begin
                    if (is_branch && cond_true) begin
                        taken = 1'b1;
                        if (opcode == OP_B) begin
                            pc_d = branch_target(pc_plus2, imm9);
                        end else begin
                            pc_d = rs_val & 16'hFFFE;
                        end
                    end else if (opcode == OP_HLT) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_plus2;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control: boot sequence, B/BR decisions, condition table,
// wrap-around, stall priority, halt and reset out of halt.
module tb_pc_control;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic [2:0]  cond;
    logic [8:0]  imm9;
    logic [15:0] rs_val;
    logic [2:0]  flags;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] pc_plus2;
    logic        fetch_en;
    logic        taken;
    logic        halted;

    int checks;
    int errors;

    pc_control #(
        .RESET_PC    (16'h0000),
        .BOOT_CYCLES (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .cond     (cond),
        .imm9     (imm9),
        .rs_val   (rs_val),
        .flags    (flags),
        .stall    (stall),
        .pc       (pc),
        .pc_plus2 (pc_plus2),
        .fetch_en (fetch_en),
        .taken    (taken),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs may be changed and outputs sampled 1 unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Jump to an arbitrary pc using an unconditional BR (RUN state assumed).
    task automatic goto_pc(input logic [15:0] target);
        opcode = OP_BR; cond = 3'b111; rs_val = target; stall = 1'b0;
        step();
        opcode = OP_ADD;
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = OP_ADD; cond = 3'b000; imm9 = 9'h000;
        rs_val = 16'h0000; flags = 3'b000; stall = 1'b0;
        #2;
        checks++;
        if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want %h", pc, 16'h0000); end
        checks++;
        if ({fetch_en, taken, halted} !== 3'b000) begin
            errors++; $display("FAIL reset_ctl got %b want 000", {fetch_en, taken, halted});
        end
        step();
    endtask

    task automatic test_boot();
        logic [15:0] exp_pc [4];
        logic        exp_fe [4];
        exp_pc = '{16'h0000, 16'h0000, 16'h0002, 16'h0004};
        exp_fe = '{1'b0, 1'b1, 1'b1, 1'b1};
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pc !== exp_pc[i]) begin errors++; $display("FAIL boot_pc[%0d] got %h want %h", i, pc, exp_pc[i]); end
            checks++;
            if (fetch_en !== exp_fe[i]) begin errors++; $display("FAIL boot_fe[%0d] got %b want %b", i, fetch_en, exp_fe[i]); end
            step();
        end
    endtask

    task automatic test_branch_b();
        goto_pc(16'h0010);
        opcode = OP_B; cond = 3'b001; flags = 3'b001; imm9 = 9'h1FE;
        #1;
        checks++;
        if (taken !== 1'b1) begin errors++; $display("FAIL b_taken got %b want 1", taken); end
        step();
        checks++;
        if (pc !== 16'h000E) begin errors++; $display("FAIL b_target got %h want %h", pc, 16'h000E); end
        goto_pc(16'h0010);
        opcode = OP_B; cond = 3'b001; flags = 3'b000; imm9 = 9'h1FE;
        #1;
        checks++;
        if (taken !== 1'b0) begin errors++; $display("FAIL b_not_taken got %b want 0", taken); end
        step();
        checks++;
        if (pc !== 16'h0012) begin errors++; $display("FAIL b_fallthru got %h want %h", pc, 16'h0012); end
    endtask

    task automatic test_branch_br();
        goto_pc(16'h0020);
        opcode = OP_BR; cond = 3'b111; rs_val = 16'h1235; flags = 3'b000;
        step();
        checks++;
        if (pc !== 16'h1234) begin errors++; $display("FAIL br_target got %h want %h", pc, 16'h1234); end
        goto_pc(16'h0020);
        opcode = OP_BR; cond = 3'b110; rs_val = 16'h1235; flags = 3'b011;
        #1;
        checks++;
        if (taken !== 1'b0) begin errors++; $display("FAIL br_v0_taken got %b want 0", taken); end
        step();
        checks++;
        if (pc !== 16'h0022) begin errors++; $display("FAIL br_v0_pc got %h want %h", pc, 16'h0022); end
    endtask

    task automatic test_wrap();
        goto_pc(16'hFFFE);
        checks++;
        if (pc_plus2 !== 16'h0000) begin errors++; $display("FAIL wrap_plus2 got %h want 0000", pc_plus2); end
        opcode = OP_ADD;
        step();
        checks++;
        if (pc !== 16'h0000) begin errors++; $display("FAIL wrap_pc got %h want 0000", pc); end
        goto_pc(16'h0004);
        opcode = OP_B; cond = 3'b111; imm9 = 9'h100;
        step();
        checks++;
        if (pc !== 16'hFE06) begin errors++; $display("FAIL b_neg_max got %h want %h", pc, 16'hFE06); end
    endtask

    task automatic test_cond_table();
        // {cond, flags(V N Z), expected taken}
        logic [6:0] vec [19];
        vec = '{
            {3'b000, 3'b000, 1'b1}, {3'b000, 3'b001, 1'b0},
            {3'b001, 3'b001, 1'b1}, {3'b001, 3'b000, 1'b0},
            {3'b010, 3'b000, 1'b1}, {3'b010, 3'b010, 1'b0}, {3'b010, 3'b001, 1'b0},
            {3'b011, 3'b010, 1'b1}, {3'b011, 3'b000, 1'b0},
            {3'b100, 3'b001, 1'b1}, {3'b100, 3'b000, 1'b1}, {3'b100, 3'b010, 1'b0},
            {3'b101, 3'b010, 1'b1}, {3'b101, 3'b001, 1'b1}, {3'b101, 3'b000, 1'b0},
            {3'b110, 3'b100, 1'b1}, {3'b110, 3'b011, 1'b0},
            {3'b111, 3'b000, 1'b1}, {3'b111, 3'b111, 1'b1}
        };
        opcode = OP_B; imm9 = 9'h000; stall = 1'b0;
        for (int i = 0; i < 19; i++) begin
            cond  = vec[i][6:4];
            flags = vec[i][3:1];
            #1;
            checks++;
            if (taken !== vec[i][0]) begin
                errors++;
                $display("FAIL cond_%b_flags_%b got %b want %b", vec[i][6:4], vec[i][3:1], taken, vec[i][0]);
            end
            step();
        end
        opcode = OP_ADD;
    endtask

    task automatic test_stall();
        logic [15:0] held;
        goto_pc(16'h0100);
        held = pc;
        opcode = OP_BR; cond = 3'b111; rs_val = 16'h4000; stall = 1'b1;
        #1;
        checks++;
        if (taken !== 1'b0) begin errors++; $display("FAIL stall_taken got %b want 0", taken); end
        step();
        checks++;
        if (pc !== held) begin errors++; $display("FAIL stall_pc got %h want %h", pc, held); end
        stall = 1'b0; opcode = OP_ADD;
        step();
        checks++;
        if (pc !== 16'h0102) begin errors++; $display("FAIL unstall_pc got %h want %h", pc, 16'h0102); end
    endtask

    task automatic test_halt();
        logic [15:0] held;
        held = pc;
        opcode = OP_HLT; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (pc !== held || halted !== 1'b0) begin
                errors++; $display("FAIL halt_stalled[%0d] got pc %h halted %b want %h 0", i, pc, halted, held);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (halted !== 1'b1 || fetch_en !== 1'b0) begin
            errors++; $display("FAIL halt_enter got halted %b fe %b want 1 0", halted, fetch_en);
        end
        opcode = OP_B; cond = 3'b111; imm9 = 9'h010;
        #1;
        checks++;
        if (taken !== 1'b0) begin errors++; $display("FAIL halt_taken got %b want 0", taken); end
        step();
        step();
        checks++;
        if (pc !== held || halted !== 1'b1) begin
            errors++; $display("FAIL halt_frozen got pc %h halted %b want %h 1", pc, halted, held);
        end
    endtask

    task automatic test_reset_from_halt();
        opcode = OP_ADD;
        rst = 1'b1;
        #1;
        checks++;
        if (pc !== 16'h0000 || halted !== 1'b0) begin
            errors++; $display("FAIL async_rst got pc %h halted %b want 0000 0", pc, halted);
        end
        step();
        rst = 1'b0;
        checks++;
        if (fetch_en !== 1'b0 || pc !== 16'h0000) begin
            errors++; $display("FAIL reboot_boot got fe %b pc %h want 0 0000", fetch_en, pc);
        end
        step();
        checks++;
        if (fetch_en !== 1'b1 || pc !== 16'h0000) begin
            errors++; $display("FAIL reboot_run got fe %b pc %h want 1 0000", fetch_en, pc);
        end
        step();
        checks++;
        if (pc !== 16'h0002) begin errors++; $display("FAIL reboot_adv got %h want 0002", pc); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_boot();
        test_branch_b();
        test_branch_br();
        test_wrap();
        test_cond_table();
        test_stall();
        test_halt();
        test_reset_from_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
